// File: rtl/mem_pkg.sv
// Shared constants, FSM state type and the stride gather used by the
// bit-strided read/write converters of the dual-bank compute memory.
package mem_pkg;

    localparam int WORD_W     = 256;
    localparam int HALF_W     = WORD_W / 2;
    localparam int ROW_W      = 1024;
    localparam int STRIDE     = 8;
    localparam int STRIDE_SH  = 3;
    localparam int ADDR_W     = 7;
    localparam int MEM_ADDR_W = ADDR_W + STRIDE_SH;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        PACK,
        HOLD
    } state_t;

    // Collect row[0], row[STRIDE], row[2*STRIDE], ... into word bits 0,1,2,...
    // Row index 0 is the MSB of the [0:ROW_W-1] declaration. Done with shifts
    // only, so every select is a constant and the result is pure wiring.
    function automatic logic [HALF_W-1:0] gather(input logic [0:ROW_W-1] row);
        logic [0:ROW_W-1] r;
        logic [HALF_W-1:0] w;
        r = row;
        w = '0;
        for (int i = 0; i < HALF_W; i++) begin
            w = {r[0], w[HALF_W-1:1]};
            r = r << STRIDE;
        end
        return w;
    endfunction

endpackage

// File: rtl/stride_gather.sv
// Combinational gather of every STRIDE-th bit of one memory row into half a word.
module stride_gather
    import mem_pkg::*;
(
    input  logic [0:ROW_W-1]  row,
    output logic [HALF_W-1:0] word
);

    assign word = gather(row);

endmodule

// File: rtl/read_converter.sv
// Read side of the bit-strided dual-bank memory path: issues one row read at
// 8*addr, waits RD_LATENCY cycles, gathers both banks into one 256-bit word and
// returns it on a valid/ready handshake.
module read_converter
    import mem_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  r_req,
    input  logic [ADDR_W-1:0]     r_addr_in,
    output logic                  r_req_ready,
    output logic                  mem_rd_en,
    output logic [MEM_ADDR_W-1:0] mem_rd_addr,
    input  logic [0:ROW_W-1]      mem_rd_data_lsb,
    input  logic [0:ROW_W-1]      mem_rd_data_msb,
    output logic [WORD_W-1:0]     r_data_out,
    output logic                  r_valid,
    input  logic                  r_ready
);

    localparam int CNT_W = 2;

    state_t             state;
    logic [CNT_W-1:0]   lat_cnt;
    logic [HALF_W-1:0]  lsb_word;
    logic [HALF_W-1:0]  msb_word;
    logic [HALF_W-1:0]  lsb_cap;
    logic [HALF_W-1:0]  msb_cap;
    logic               capture;

    stride_gather u_gather_lsb (
        .row  (mem_rd_data_lsb),
        .word (lsb_word)
    );

    stride_gather u_gather_msb (
        .row  (mem_rd_data_msb),
        .word (msb_word)
    );

    // Memory data is valid in the WAIT cycle where the latency counter hits zero.
    assign capture = (state == WAIT) && (lat_cnt == '0);

    // Hold the gathered rows until PACK; pure data, so no reset is needed.
    always_ff @(posedge clk) begin
        if (capture) begin
            lsb_cap <= lsb_word;
            msb_cap <= msb_word;
        end
    end

    // Control FSM with registered handshake, memory strobe and output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            r_req_ready <= 1'b1;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            r_valid     <= 1'b0;
            r_data_out  <= '0;
            lat_cnt     <= '0;
        end else begin
            mem_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (r_req) begin
                        // Address scaling is a shift; 127*8 = 1016 fits in 10 bits.
                        mem_rd_addr <= {r_addr_in, {STRIDE_SH{1'b0}}};
                        mem_rd_en   <= 1'b1;
                        r_req_ready <= 1'b0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    lat_cnt <= CNT_W'(RD_LATENCY - 1);
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        state <= PACK;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                PACK: begin
                    r_data_out <= {msb_cap, lsb_cap};
                    r_valid    <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (r_ready) begin
                        r_valid     <= 1'b0;
                        r_req_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    r_valid     <= 1'b0;
                    r_req_ready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
